// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request target in front of an on-chip
// register array. A request is captured from IDLE, held for WAIT_CYCLES
// wait states, then completed with a one-cycle ack carrying read data and
// an out-of-range error flag.
module mem_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic              err,
  output logic [15:0]       txn_cnt
);

  // One extra bit so DEPTH == 2**ADDR_W is representable for the range compare.
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  // Counter preload; the WAIT state is bypassed entirely when WAIT_CYCLES is 0.
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          wait_cnt_r;
  logic [3:0]          wait_cnt_s;
  logic                capture_s;
  logic                access_s;
  logic                in_range_s;

  logic                wr_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   din_r;

  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                ack_r;
  logic                err_r;
  logic [DATA_W-1:0]   dout_r;
  logic [15:0]         txn_cnt_r;

  // Only the captured address decides range; live inputs never reach the access.
  assign in_range_s = ({1'b0, addr_r} < DEPTH_C);

  // Next-state, wait counter and capture/access strobes.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    capture_s  = 1'b0;
    access_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (en) begin
          capture_s = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_s    = S_WAIT;
            wait_cnt_s = WAIT_LOAD;
          end else begin
            state_s    = S_RESP;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_s = S_RESP;
        end else begin
          wait_cnt_s = wait_cnt_r - 4'd1;
        end
      end
      S_RESP: begin
        access_s = 1'b1;
        state_s  = S_IDLE;
      end
      default: begin
        state_s    = S_IDLE;
        wait_cnt_s = 4'd0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Request capture; only loaded when a request is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r   <= 1'b0;
      addr_r <= '0;
      din_r  <= '0;
    end else if (capture_s) begin
      wr_r   <= wr;
      addr_r <= addr;
      din_r  <= din;
    end
  end

  // Register array; writes happen only on the completion edge and only in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (access_s && wr_r && in_range_s) begin
      mem_r[addr_r] <= din_r;
    end
  end

  // Completion outputs: ack/err pulse, read data, transaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      dout_r    <= '0;
      txn_cnt_r <= 16'd0;
    end else begin
      ack_r <= access_s;
      err_r <= access_s & ~in_range_s;
      if (access_s) begin
        txn_cnt_r <= txn_cnt_r + 16'd1;
        if (!in_range_s) begin
          dout_r <= '0;
        end else if (!wr_r) begin
          dout_r <= mem_r[addr_r];
        end
      end
    end
  end

  assign busy    = (state_r != S_IDLE);
  assign ack     = ack_r;
  assign err     = err_r;
  assign dout    = dout_r;
  assign txn_cnt = txn_cnt_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (2 wait states with a
// 48-entry array, and 0 wait states with a full 64-entry array).
module tb_mem_responder;

  localparam int DEPTH_A = 48;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_Z = 64;
  localparam int WAIT_Z  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        en_a = 1'b0, wr_a = 1'b0;
  logic [5:0]  addr_a = 6'd0;
  logic [7:0]  din_a = 8'd0;
  logic        busy_a, ack_a, err_a;
  logic [7:0]  dout_a;
  logic [15:0] txn_cnt_a;

  logic        en_z = 1'b0, wr_z = 1'b0;
  logic [5:0]  addr_z = 6'd0;
  logic [7:0]  din_z = 8'd0;
  logic        busy_z, ack_z, err_z;
  logic [7:0]  dout_z;
  logic [15:0] txn_cnt_z;

  mem_responder #(.ADDR_W(6), .DATA_W(8), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .wr(wr_a), .addr(addr_a), .din(din_a),
    .busy(busy_a), .ack(ack_a), .dout(dout_a), .err(err_a), .txn_cnt(txn_cnt_a));

  mem_responder #(.ADDR_W(6), .DATA_W(8), .DEPTH(DEPTH_Z), .WAIT_CYCLES(WAIT_Z)) u_dut_z (
    .clk(clk), .rst(rst), .en(en_z), .wr(wr_z), .addr(addr_z), .din(din_z),
    .busy(busy_z), .ack(ack_z), .dout(dout_z), .err(err_z), .txn_cnt(txn_cnt_z));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [7:0]  dout;
    logic [15:0] cnt;
    int          ack_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_z[$];

  // Reference model: plain memory image per unit, last returned data, ack count.
  logic [7:0]  ref_mem [2][64];
  logic [7:0]  last_d  [2];
  logic [15:0] cnt_m   [2];

  bit junk_fixed = 1'b0;
  bit hold_z     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 64; i++) ref_mem[u][i] = 8'd0;
      last_d[u] = 8'd0;
      cnt_m[u]  = 16'd0;
    end
  endtask

  task automatic model_push(input int unit, input logic w, input logic [5:0] a,
                            input logic [7:0] d, input int acc_cyc);
    exp_t e;
    int   depth;
    int   waits;
    depth = (unit == 0) ? DEPTH_A : DEPTH_Z;
    waits = (unit == 0) ? WAIT_A : WAIT_Z;
    if (int'(a) >= depth) begin
      e.err = 1'b1;
      e.dout = 8'd0;
    end else if (w) begin
      ref_mem[unit][a] = d;
      e.err = 1'b0;
      e.dout = last_d[unit];
    end else begin
      e.err = 1'b0;
      e.dout = ref_mem[unit][a];
    end
    last_d[unit] = e.dout;
    cnt_m[unit]  = cnt_m[unit] + 16'd1;
    e.cnt        = cnt_m[unit];
    e.ack_cyc    = acc_cyc + waits + 1;
    if (unit == 0) q_a.push_back(e);
    else q_z.push_back(e);
  endtask

  task automatic drive(input int unit, input logic e, input logic w,
                       input logic [5:0] a, input logic [7:0] d);
    if (unit == 0) begin
      en_a = e; wr_a = w; addr_a = a; din_a = d;
    end else begin
      en_z = e; wr_z = w; addr_z = a; din_z = d;
    end
  endtask

  function automatic logic is_busy(input int unit);
    return (unit == 0) ? busy_a : busy_z;
  endfunction

  // Input noise applied while the unit is busy; all of it must be ignored.
  task automatic junk(input int unit);
    if (junk_fixed) begin
      drive(unit, 1'b1, 1'b1, 6'd7, 8'h3C);
    end else begin
      drive(unit, (unit == 1 && hold_z) ? 1'b1 : 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic issue(input int unit, input logic w, input logic [5:0] a, input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (is_busy(unit) && guard < 100) begin
      junk(unit);
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout unit %0d: busy stuck high, expected low within 100 cycles", unit);
      return;
    end
    drive(unit, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    model_push(unit, w, a, d, cyc);
    if (!(unit == 1 && hold_z)) drive(unit, 1'b0, w, a, d);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((q_a.size() != 0 || q_z.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending a=%0d z=%0d, expected 0", q_a.size(), q_z.size());
    end
    @(negedge clk);
  endtask

  task automatic mon_check(input int unit, input logic e_err, input logic [7:0] e_dout,
                           input logic [15:0] e_cnt);
    exp_t e;
    string tag;
    tag = (unit == 0) ? "a" : "z";
    if ((unit == 0 && q_a.size() == 0) || (unit == 1 && q_z.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL spurious_ack_%s: ack=1 with no request outstanding, expected ack=0", tag);
    end else begin
      e = (unit == 0) ? q_a.pop_front() : q_z.pop_front();
      chk({"err_", tag}, 32'(e_err), 32'(e.err));
      chk({"dout_", tag}, 32'(e_dout), 32'(e.dout));
      chk({"txn_cnt_", tag}, 32'(e_cnt), 32'(e.cnt));
      chk({"latency_", tag}, 32'(cyc), 32'(e.ack_cyc));
    end
  endtask

  // Monitor for unit A: every ack cycle pops and compares one expected response.
  always @(negedge clk) if (!rst && ack_a) mon_check(0, err_a, dout_a, txn_cnt_a);

  // Monitor for unit Z.
  always @(negedge clk) if (!rst && ack_z) mon_check(1, err_z, dout_z, txn_cnt_z);

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ack_a", 32'(ack_a), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_cnt_a", 32'(txn_cnt_a), 32'd0);
    chk("rst_busy_z", 32'(busy_z), 32'd0);
    chk("rst_cnt_z", 32'(txn_cnt_z), 32'd0);

    // Fresh memory reads as zero; then write/read-back latency.
    issue(0, 1'b0, 6'd10, 8'h00);
    issue(0, 1'b1, 6'd5, 8'hA5);
    issue(0, 1'b0, 6'd5, 8'h00);

    // Requests presented while busy must never be latched.
    junk_fixed = 1'b1;
    issue(0, 1'b0, 6'd7, 8'h00);
    junk_fixed = 1'b0;
    issue(0, 1'b0, 6'd7, 8'h00);

    // Out-of-range write and read.
    issue(0, 1'b1, 6'd50, 8'hFF);
    issue(0, 1'b0, 6'd50, 8'h00);
    issue(0, 1'b0, 6'd47, 8'h00);

    // Zero-wait unit, en held high, back-to-back writes then reads.
    hold_z = 1'b1;
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 6'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 6'(i), 8'h00);
    hold_z = 1'b0;
    drive(1, 1'b0, 1'b0, 6'd0, 8'd0);
    wait_drain();
    chk("z_txn_cnt_8", 32'(txn_cnt_z), 32'd8);

    // Reset during WAIT aborts the write.
    issue(0, 1'b1, 6'd9, 8'h55);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_ack", 32'(ack_a), 32'd0);
    if (q_a.size() != 0) void'(q_a.pop_back());
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_cnt", 32'(txn_cnt_a), 32'd0);
    issue(0, 1'b0, 6'd9, 8'h00);

    // Randomized traffic on both units.
    for (int n = 0; n < 150; n++) begin
      int unit;
      unit = ($urandom_range(0, 3) == 0) ? 1 : 0;
      issue(unit, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
